pc_seq_unit: RTL and testbench

- Registered program-counter unit for the fetch stage.
- Successor to the combinational next-PC adder. It keeps the PC in a register and computes next-PC for five operations: increment, branch, jump, jump-and-link and return.
- Adds a parametrised return-address stack (RAS), an advance/stall handshake and sticky stack-error flags.
- Output `pc` drives instruction-memory address; `rlink` feeds the register-file write port on JAL.

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/ras_stack.sv | 61 ++++++
 rtl/pc_seq_unit.sv | 109 ++++++++++
 tb/tb_pc_seq_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage program-counter unit: the operation
// encoding and the fixed-priority selector that maps request enables onto it.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    PC_INC    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_JAL    = 3'd3,
    PC_RET    = 3'd4
  } pc_op_e;

  // Fixed priority: JAL > RET > JUMP > BRANCH > increment.
  function automatic pc_op_e pc_op_sel(input logic jal_en, input logic ret_en,
                                       input logic jump_en, input logic branch_en);
    if (jal_en)         return PC_JAL;
    else if (ret_en)    return PC_RET;
    else if (jump_en)   return PC_JUMP;
    else if (branch_en) return PC_BRANCH;
    else                return PC_INC;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest
// entry, and a pop from an empty stack leaves it unchanged. Both raise one-cycle events.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [WIDTH-1:0]               i_push_data,
  output logic [WIDTH-1:0]               o_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] o_count,
  output logic                           o_overflow_evt,
  output logic                           o_underflow_evt
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic [PW-1:0]    w_ptr_inc;
  logic [PW-1:0]    w_ptr_dec;

  assign w_full  = (r_count == CW'(RAS_DEPTH));
  assign w_empty = (r_count == '0);

  // The pointer wraps explicitly, so the depth does not have to be a power of two.
  assign w_ptr_inc = (r_ptr == PW'(RAS_DEPTH - 1)) ? '0 : r_ptr + PW'(1);
  assign w_ptr_dec = (r_ptr == '0) ? PW'(RAS_DEPTH - 1) : r_ptr - PW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= w_ptr_inc;
      if (!w_full) r_count <= r_count + CW'(1);
    end else if (i_pop && !w_empty) begin
      r_ptr   <= w_ptr_dec;
      r_count <= r_count - CW'(1);
    end
  end

  // Stack contents are don't-care after reset, so this storage has no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_ptr_inc] <= i_push_data;
  end

  assign o_top           = r_mem[r_ptr];
  assign o_count         = r_count;
  assign o_overflow_evt  = i_push && w_full;
  assign o_underflow_evt = i_pop && w_empty;

endmodule

// File: rtl/pc_seq_unit.sv
// Registered fetch-stage program counter with a next-PC mux, a return-address
// stack, an advance/stall handshake and sticky stack-error flags.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_PC   = 0,
  parameter int BRANCH_ADJ = 2,
  parameter int JUMP_ADJ   = 1,
  parameter int LINK_ADJ   = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           adv,
  input  logic                           jal_en,
  input  logic                           ret_en,
  input  logic                           jump_en,
  input  logic                           branch_en,
  input  logic [WIDTH-1:0]               target,
  input  logic [WIDTH-1:0]               imm,
  input  logic                           clr_err,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_next,
  output logic [WIDTH-1:0]               rlink,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_rlink;
  logic             r_ovf;
  logic             r_unf;
  pc_op_e           w_op;
  logic [WIDTH-1:0] w_link;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_ras_top;
  logic [CW-1:0]    w_ras_count;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  assign w_op   = pc_op_sel(jal_en, ret_en, jump_en, branch_en);
  assign w_link = r_pc + WIDTH'(LINK_ADJ);
  assign w_push = adv && (w_op == PC_JAL);
  assign w_pop  = adv && (w_op == PC_RET);

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_push          (w_push),
    .i_pop           (w_pop),
    .i_push_data     (w_link),
    .o_top           (w_ras_top),
    .o_count         (w_ras_count),
    .o_overflow_evt  (w_ovf_evt),
    .o_underflow_evt (w_unf_evt)
  );

  // imm is already WIDTH bits, so modulo-2^WIDTH addition sign-extends it implicitly.
  always_comb begin
    w_pc_next = r_pc + WIDTH'(1);
    unique case (w_op)
      PC_BRANCH: w_pc_next = r_pc + imm - WIDTH'(BRANCH_ADJ);
      PC_JUMP:   w_pc_next = target - WIDTH'(JUMP_ADJ);
      PC_JAL:    w_pc_next = target;
      PC_RET:    w_pc_next = ((w_ras_count == '0) ? target : w_ras_top) - WIDTH'(JUMP_ADJ);
      default:   w_pc_next = r_pc + WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= WIDTH'(RESET_PC);
      r_rlink <= '0;
    end else if (adv) begin
      r_pc <= w_pc_next;
      if (w_op == PC_JAL) r_rlink <= w_link;
    end
  end

  // A new event takes precedence over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_evt)    r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_unf_evt)    r_unf <= 1'b1;
      else if (clr_err) r_unf <= 1'b0;
    end
  end

  assign pc            = r_pc;
  assign pc_next       = w_pc_next;
  assign rlink         = r_rlink;
  assign ras_count     = w_ras_count;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: directed steps queue their expected results,
// and a monitor checks pc_next before each edge and the registered state after it.
module tb_pc_seq_unit;

  logic        clk;
  logic        reset_n;
  logic        adv, jal_en, ret_en, jump_en, branch_en, clr_err;
  logic [15:0] target, imm;
  logic [15:0] pc, pc_next, rlink;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    bit          chk_next;
    logic [15:0] exp_next;
    bit          chk_pre;
    bit          chk_post;
    logic [15:0] exp_pc;
    logic [15:0] exp_rl;
    logic [2:0]  exp_cnt;
    bit          exp_ov;
    bit          exp_un;
  } exp_t;

  exp_t sb_q[$];

  pc_seq_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adv           (adv),
    .jal_en        (jal_en),
    .ret_en        (ret_en),
    .jump_en       (jump_en),
    .branch_en     (branch_en),
    .target        (target),
    .imm           (imm),
    .clr_err       (clr_err),
    .pc            (pc),
    .pc_next       (pc_next),
    .rlink         (rlink),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s.%s: got 0x%04h, expected 0x%04h", nm, fld, act, exp);
    end
  endtask

  task automatic check_state(input exp_t e, input string phase);
    cmp({e.name, phase}, "pc", pc, e.exp_pc);
    cmp({e.name, phase}, "rlink", rlink, e.exp_rl);
    cmp({e.name, phase}, "ras_count", 16'(ras_count), 16'(e.exp_cnt));
    cmp({e.name, phase}, "ras_overflow", 16'(ras_overflow), 16'(e.exp_ov));
    cmp({e.name, phase}, "ras_underflow", 16'(ras_underflow), 16'(e.exp_un));
  endtask

  // Monitor: one scoreboard entry per cycle, pre-edge then post-edge checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk_next) cmp(e.name, "pc_next", pc_next, e.exp_next);
        if (e.chk_pre) check_state(e, "/pre");
        @(posedge clk);
        #1;
        if (e.chk_post) check_state(e, "/post");
        $display("[TB] %-14s pc=0x%04h pc_next_exp=0x%04h rlink=0x%04h cnt=%0d ovf=%0b unf=%0b",
                 e.name, pc, e.exp_next, rlink, ras_count, ras_overflow, ras_underflow);
      end
    end
  end

  task automatic drive(input bit a, input bit j, input bit r, input bit jp, input bit b,
                       input logic [15:0] t, input logic [15:0] im, input bit c);
    adv = a; jal_en = j; ret_en = r; jump_en = jp; branch_en = b;
    target = t; imm = im; clr_err = c;
  endtask

  // One committed-or-stalled step with the state expected after the next edge.
  task automatic step(input string nm, input bit a, input bit j, input bit r, input bit jp,
                      input bit b, input logic [15:0] t, input logic [15:0] im, input bit c,
                      input logic [15:0] nx, input logic [15:0] p, input logic [15:0] rl,
                      input logic [2:0] cnt, input bit ov, input bit un);
    exp_t e;
    @(negedge clk);
    reset_n = 1'b1;
    drive(a, j, r, jp, b, t, im, c);
    e = '{name: nm, chk_next: 1'b1, exp_next: nx, chk_pre: 1'b0, chk_post: 1'b1,
          exp_pc: p, exp_rl: rl, exp_cnt: cnt, exp_ov: ov, exp_un: un};
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // While held in reset: pc=0, so increment offers pc_next=1 but nothing commits.
    @(negedge clk);
    e = '{name: "reset", chk_next: 1'b1, exp_next: 16'h0001, chk_pre: 1'b1, chk_post: 1'b1,
          exp_pc: 16'h0000, exp_rl: 16'h0000, exp_cnt: 3'd0, exp_ov: 1'b0, exp_un: 1'b0};
    sb_q.push_back(e);

    //    name           adv jal ret jmp br  target    imm       clr  pc_next   pc        rlink     cnt ov un
    step("inc1",         1,  0,  0,  0,  0,  16'h0000, 16'h0000, 0,   16'h0001, 16'h0001, 16'h0000, 0,  0, 0);
    step("inc2",         1,  0,  0,  0,  0,  16'h0000, 16'h0000, 0,   16'h0002, 16'h0002, 16'h0000, 0,  0, 0);
    step("inc3",         1,  0,  0,  0,  0,  16'h0000, 16'h0000, 0,   16'h0003, 16'h0003, 16'h0000, 0,  0, 0);
    step("jump_to_10",   1,  0,  0,  1,  0,  16'h0011, 16'h0000, 0,   16'h0010, 16'h0010, 16'h0000, 0,  0, 0);
    step("br_stall",     0,  0,  0,  0,  1,  16'h0000, 16'hFFF0, 0,   16'hFFFE, 16'h0010, 16'h0000, 0,  0, 0);
    step("br_wrap",      1,  0,  0,  0,  1,  16'h0000, 16'hFFF0, 0,   16'hFFFE, 16'hFFFE, 16'h0000, 0,  0, 0);
    step("jump_to_20",   1,  0,  0,  1,  0,  16'h0021, 16'h0000, 0,   16'h0020, 16'h0020, 16'h0000, 0,  0, 0);
    step("jal_100",      1,  1,  0,  0,  0,  16'h0100, 16'h0000, 0,   16'h0100, 16'h0100, 16'h0020, 1,  0, 0);
    step("ret_pop",      1,  0,  1,  0,  0,  16'h0555, 16'h0000, 0,   16'h001F, 16'h001F, 16'h0020, 0,  0, 0);
    step("jal_stall",    0,  1,  0,  0,  0,  16'h0300, 16'h0000, 0,   16'h0300, 16'h001F, 16'h0020, 0,  0, 0);
    step("jump_to_1",    1,  0,  0,  1,  0,  16'h0002, 16'h0000, 0,   16'h0001, 16'h0001, 16'h0020, 0,  0, 0);
    step("jal_a",        1,  1,  0,  0,  0,  16'h0002, 16'h0000, 0,   16'h0002, 16'h0002, 16'h0001, 1,  0, 0);
    step("jal_b",        1,  1,  0,  0,  0,  16'h0003, 16'h0000, 0,   16'h0003, 16'h0003, 16'h0002, 2,  0, 0);
    step("jal_c",        1,  1,  0,  0,  0,  16'h0004, 16'h0000, 0,   16'h0004, 16'h0004, 16'h0003, 3,  0, 0);
    step("jal_d",        1,  1,  0,  0,  0,  16'h0005, 16'h0000, 0,   16'h0005, 16'h0005, 16'h0004, 4,  0, 0);
    step("jal_ovf",      1,  1,  0,  0,  0,  16'h0006, 16'h0000, 0,   16'h0006, 16'h0006, 16'h0005, 4,  1, 0);
    step("ret_5",        1,  0,  1,  0,  0,  16'h0777, 16'h0000, 0,   16'h0004, 16'h0004, 16'h0005, 3,  1, 0);
    step("ret_4",        1,  0,  1,  0,  0,  16'h0777, 16'h0000, 0,   16'h0003, 16'h0003, 16'h0005, 2,  1, 0);
    step("ret_3",        1,  0,  1,  0,  0,  16'h0777, 16'h0000, 0,   16'h0002, 16'h0002, 16'h0005, 1,  1, 0);
    step("ret_2",        1,  0,  1,  0,  0,  16'h0777, 16'h0000, 0,   16'h0001, 16'h0001, 16'h0005, 0,  1, 0);
    step("clr_ovf",      1,  0,  0,  0,  0,  16'h0000, 16'h0000, 1,   16'h0002, 16'h0002, 16'h0005, 0,  0, 0);
    step("ret_empty",    1,  0,  1,  0,  0,  16'h0040, 16'h0000, 0,   16'h003F, 16'h003F, 16'h0005, 0,  0, 1);
    step("clr_unf",      1,  0,  0,  0,  0,  16'h0000, 16'h0000, 1,   16'h0040, 16'h0040, 16'h0005, 0,  0, 0);
    step("unf_and_clr",  1,  0,  1,  0,  0,  16'h0040, 16'h0000, 1,   16'h003F, 16'h003F, 16'h0005, 0,  0, 1);
    step("clr_stalled",  0,  0,  0,  0,  0,  16'h0000, 16'h0000, 1,   16'h0040, 16'h003F, 16'h0005, 0,  0, 0);
    step("ret_stalled",  0,  0,  1,  0,  0,  16'h0040, 16'h0000, 0,   16'h003F, 16'h003F, 16'h0005, 0,  0, 0);
    step("prio_jal",     1,  1,  1,  1,  0,  16'h0200, 16'h0000, 0,   16'h0200, 16'h0200, 16'h003F, 1,  0, 0);
    step("ret_3f",       1,  0,  1,  0,  0,  16'h0999, 16'h0000, 0,   16'h003E, 16'h003E, 16'h003F, 0,  0, 0);
    step("ret_empty2",   1,  0,  1,  0,  0,  16'h0010, 16'h0000, 0,   16'h000F, 16'h000F, 16'h003F, 0,  0, 1);
    step("br_fwd",       1,  0,  0,  0,  1,  16'h0000, 16'h0005, 0,   16'h0012, 16'h0012, 16'h003F, 0,  0, 1);

    // Reset asserted mid-cycle: state must clear before the next edge.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, 16'h0000, 1'b0);
    e = '{name: "async_reset", chk_next: 1'b1, exp_next: 16'h0400, chk_pre: 1'b1, chk_post: 1'b1,
          exp_pc: 16'h0000, exp_rl: 16'h0000, exp_cnt: 3'd0, exp_ov: 1'b0, exp_un: 1'b0};
    sb_q.push_back(e);
    #2 reset_n = 1'b0;

    step("post_reset",   1,  0,  0,  0,  0,  16'h0000, 16'h0000, 0,   16'h0001, 16'h0001, 16'h0000, 0,  0, 0);

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
